cpu_step_controller: RTL and testbench

//   Consumes the slow toggling output of the board slow-clock divider and turns it into a
//   one-cycle CPU clock-enable pulse (cpu_en) in the 25 MHz clk domain.
//   Two push buttons control it: RUN/PAUSE toggle and single STEP.

---
 rtl/frank_pkg.sv | 18 +
 rtl/cpu_step_controller_debouncer.sv | 50 +++++
 rtl/cpu_step_controller.sv | 109 ++++++++++
 tb/tb_cpu_step_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frank_pkg.sv
// Shared board constants and the step-controller state type.
// CLK_HZ must match the value used by the slow-clock divider.
package frank_pkg;

  localparam int CLK_HZ = 25_000_000;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2
  } step_state_t;

  // Number of clk cycles in a debounce window of the given length in milliseconds.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/cpu_step_controller_debouncer.sv
// button_debouncer: 2-FF synchronizer, stability counter and a one-cycle press pulse
// on each accepted 0->1 transition of the debounced level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);
  import frank_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // The level only moves after an unbroken run of disagreeing samples.
      if (r_sync2 != r_level) begin
        if (r_cnt == LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= r_sync2;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/cpu_step_controller.sv
// cpu_step_controller: turns slow_clk rising edges and RUN/STEP buttons into a
// one-cycle CPU enable pulse. Optional FAST_RUN_EN adds fast_mode (enable every cycle in RUN).
module cpu_step_controller #(
  parameter int CLK_HZ          = frank_pkg::CLK_HZ,
  parameter int DEBOUNCE_CYCLES = frank_pkg::ms_to_cycles(CLK_HZ, 10),
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             btn_run,
  input  logic             btn_step,
`ifdef FAST_RUN_EN
  input  logic             fast_mode,
`endif
  output logic             cpu_en,
  output logic             running,
  output logic [CNT_W-1:0] step_count
);
  import frank_pkg::*;

  logic w_run_press;
  logic w_step_press;
  logic w_slow_rise;

  step_state_t      r_state;
  logic             r_cpu_en;
  logic             r_running;
  logic             r_slow_prev;
  logic [CNT_W-1:0] r_step_count;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_run),
    .o_press (w_run_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_step),
    .o_press (w_step_press)
  );

  // slow_clk already lives in the clk domain; prev resets high so no rise is seen at release.
  assign w_slow_rise = slow_clk & ~r_slow_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= PAUSE;
      r_cpu_en     <= 1'b0;
      r_running    <= 1'b0;
      r_slow_prev  <= 1'b1;
      r_step_count <= '0;
    end else begin
      r_slow_prev  <= slow_clk;
      r_step_count <= r_step_count + CNT_W'(r_cpu_en);
      r_cpu_en     <= 1'b0;
      case (r_state)
        PAUSE: begin
          if (w_run_press) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end else if (w_step_press) begin
            r_state   <= STEP;
            r_running <= 1'b0;
          end else begin
            r_running <= 1'b0;
          end
        end
        STEP: begin
          r_cpu_en  <= 1'b1;
          r_state   <= PAUSE;
          r_running <= 1'b0;
        end
        RUN: begin
          // A pause request beats a coinciding slow edge: no enable is issued.
          if (w_run_press) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end else begin
            r_running <= 1'b1;
`ifdef FAST_RUN_EN
            if (fast_mode) begin
              r_cpu_en <= 1'b1;
            end else if (w_slow_rise) begin
              r_cpu_en <= 1'b1;
            end
`else
            if (w_slow_rise) begin
              r_cpu_en <= 1'b1;
            end
`endif
          end
        end
        default: begin
          r_state   <= PAUSE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_en     = r_cpu_en;
  assign running    = r_running;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Scoreboard bench for cpu_step_controller: a behavioural model predicts enable pulses
// (by cycle number) into a queue; a monitor pops and compares on every cycle.
module tb_cpu_step_controller;

  localparam int D  = 4;
  localparam int CW = 4;

  localparam int M_PAUSE = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          slow_clk = 1'b1;
  logic          btn_run = 1'b0;
  logic          btn_step = 1'b0;
  logic          fast_mode = 1'b0;
  logic          cpu_en;
  logic          running;
  logic [CW-1:0] step_count;

  cpu_step_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .slow_clk   (slow_clk),
    .btn_run    (btn_run),
    .btn_step   (btn_step),
`ifdef FAST_RUN_EN
    .fast_mode  (fast_mode),
`endif
    .cpu_en     (cpu_en),
    .running    (running),
    .step_count (step_count)
  );

  always #20 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  int exp_cnt = 0;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Button model: raw input seen two samples late, level flips once the last D
  // delayed samples all disagree with it; a flip to 1 is a press.
  typedef struct packed {
    logic [1:0]   dly;
    logic [D-1:0] win;
    logic         lvl;
  } btn_m_t;

  function automatic btn_m_t btn_upd(input btn_m_t s, input logic raw, output logic prs);
    btn_m_t n = s;
    n.dly = {s.dly[0], raw};
    n.win = {s.win[D-2:0], s.dly[1]};
    prs   = 1'b0;
    if (n.win == (s.lvl ? {D{1'b0}} : {D{1'b1}})) begin
      n.lvl = ~s.lvl;
      prs   = n.lvl;
    end
    return n;
  endfunction

  btn_m_t m_run_b, m_step_b;
  logic   m_run_prs, m_step_prs, m_slow_last, m_running;
  int     m_mode;

  // Reference model, evaluated at each active edge.
  initial begin
    logic pulse, sr, p_run, p_step;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        edge_cnt    = 0;
        m_run_b     = '0;
        m_step_b    = '0;
        m_run_prs   = 1'b0;
        m_step_prs  = 1'b0;
        m_slow_last = 1'b1;
        m_running   = 1'b0;
        m_mode      = M_PAUSE;
        exp_q.delete();
      end else begin
        edge_cnt++;
        sr = slow_clk && !m_slow_last;
        m_slow_last = slow_clk;
        pulse = 1'b0;
        case (m_mode)
          M_PAUSE: if (m_run_prs) m_mode = M_RUN; else if (m_step_prs) m_mode = M_STEP;
          M_STEP: begin pulse = 1'b1; m_mode = M_PAUSE; end
          default: begin
            if (m_run_prs) m_mode = M_PAUSE;
            else if (fast_mode || sr) pulse = 1'b1;
          end
        endcase
        m_running = (m_mode == M_RUN);
        if (pulse) exp_q.push_back(edge_cnt);
        m_run_b  = btn_upd(m_run_b, btn_run, p_run);
        m_step_b = btn_upd(m_step_b, btn_step, p_step);
        m_run_prs  = p_run;
        m_step_prs = p_step;
      end
    end
  end

  // Monitor: compares every cycle on the inactive edge.
  initial begin
    logic exp_p;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_cpu_en", cpu_en, 0);
        check("rst_running", running, 0);
        check("rst_step_count", step_count, 0);
        exp_cnt = 0;
      end else begin
        exp_p = (exp_q.size() > 0) && (exp_q[0] == edge_cnt);
        if (exp_p) void'(exp_q.pop_front());
        $display("[TB] cyc %0d cpu_en=%0b running=%0b step_count=%0d", edge_cnt, cpu_en, running, step_count);
        check("cpu_en", cpu_en, int'(exp_p));
        check("running", running, int'(m_running));
        check("step_count", step_count, exp_cnt);
        if (exp_p) exp_cnt = (exp_cnt + 1) % (1 << CW);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_btn(input bit is_run, input int hold);
    if (is_run) btn_run = 1'b1; else btn_step = 1'b1;
    tick(hold);
    if (is_run) btn_run = 1'b0; else btn_step = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #5 rst = 1'b1;
    tick(3);
    #5 rst = 1'b0;
  endtask

  initial begin
    int c0;
    // Reset with activity on every input; buttons held across release.
    btn_run  = 1'b1;
    btn_step = 1'b1;
    repeat (10) begin
      @(negedge clk);
      slow_clk = ~slow_clk;
    end
    #5 rst = 1'b0;
    @(negedge clk);
    slow_clk = 1'b1;
    tick(8);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    tick(10);
    check("held_across_reset_run", running, 1);
    push_btn(1'b1, 8);
    tick(10);
    check("paused", running, 0);

    // Bounce filter, then one clean step.
    for (int w = 1; w <= 3; w++) begin
      btn_step = 1'b1;
      tick(w);
      btn_step = 1'b0;
      tick(8);
    end
    check("glitch_no_step", step_count, 0);
    push_btn(1'b0, 8);
    tick(10);
    check("one_step", step_count, 1);
    check("step_back_pause", running, 0);

    // Run paced by slow_clk.
    push_btn(1'b1, 8);
    tick(10);
    repeat (5) begin
      slow_clk = 1'b0;
      tick(10);
      slow_clk = 1'b1;
      tick(10);
    end
    check("run_count", step_count, 6);
    check("run_running", running, 1);

    // Pause press lands on the same edge as a slow rise.
    slow_clk = 1'b0;
    tick(2);
    btn_run = 1'b1;
    tick(6);
    slow_clk = 1'b1;
    tick(2);
    btn_run = 1'b0;
    tick(10);
    check("prio_running", running, 0);
    check("prio_count", step_count, 6);

    // Simultaneous run and step presses in PAUSE.
    btn_run  = 1'b1;
    btn_step = 1'b1;
    tick(8);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    tick(10);
    check("both_run", running, 1);
    check("both_count", step_count, 6);
    push_btn(1'b1, 8);
    tick(10);

    // Counter wrap.
    do_reset();
    repeat (17) begin
      push_btn(1'b0, 6);
      tick(8);
    end
    check("wrap_count", step_count, 1);

    // Reset in the middle of a RUN pulse.
    push_btn(1'b1, 8);
    tick(10);
    slow_clk = 1'b0;
    tick(3);
    slow_clk = 1'b1;
    @(posedge clk);
    #5;
    check("pre_rst_cpu_en", cpu_en, 1);
    rst = 1'b1;
    #1;
    check("midrun_rst_cpu_en", cpu_en, 0);
    check("midrun_rst_running", running, 0);
    check("midrun_rst_count", step_count, 0);
    tick(3);
    #5 rst = 1'b0;
    tick(5);

`ifdef FAST_RUN_EN
    push_btn(1'b1, 8);
    tick(4);
    c0 = int'(step_count);
    fast_mode = 1'b1;
    tick(20);
    fast_mode = 1'b0;
    tick(1);
    check("fast_count", step_count, (c0 + 20) % (1 << CW));
    push_btn(1'b1, 8);
    tick(10);
`else
    c0 = 0;
`endif

    // Randomised soak against the model.
    do_reset();
    repeat (800) begin
      @(negedge clk);
      if ($urandom_range(0, 14) == 0) btn_run = ~btn_run;
      if ($urandom_range(0, 9) == 0) btn_step = ~btn_step;
      if ($urandom_range(0, 3) == 0) slow_clk = ~slow_clk;
`ifdef FAST_RUN_EN
      if ($urandom_range(0, 29) == 0) fast_mode = ~fast_mode;
`endif
    end
    btn_run  = 1'b0;
    btn_step = 1'b0;
    tick(12);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
